nf_10g_pause_scheduler: RTL and testbench

//  Flow-control scheduler for the 10G MAC pause request port (s_axis_pause_tdata/tvalid), clk156 domain.

---
 rtl/nf_10g_pkg.sv | 14 +
 rtl/nf_sat_counter.sv | 38 +++
 rtl/nf_10g_pause_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_nf_10g_pause_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/nf_10g_pkg.sv
// Shared types and constants for the 10G flow-control blocks.
package nf_10g_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_XOFF_REQ = 2'd1,
      ST_PAUSED   = 2'd2,
      ST_XON_REQ  = 2'd3
   } pause_state_e;

   localparam logic [15:0] XON_QUANTA        = 16'h0000;
   localparam int          CYCLES_PER_QUANTA = 8;

endpackage

// File: rtl/nf_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module nf_sat_counter
   import nf_10g_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // next count: clear, else increment unless already all-ones
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // count register
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/nf_10g_pause_scheduler.sv
// Pause-frame request scheduler for the 10G MAC: hysteresis on RX fill,
// XOFF refresh before the peer's pause expires, minimum gap between requests.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no pause in force, watching for fill >= high_water
// XOFF_REQ | XOFF wanted, waiting for gap to expire (refresh: already paused)
// PAUSED   | XOFF in force, refresh timer counting down
// XON_REQ  | XON wanted, waiting for gap to expire
module nf_10g_pause_scheduler
   import nf_10g_pkg::*;
#(
   parameter int                       C_FILL_WIDTH     = 12,
   parameter logic [15:0]              C_PAUSE_QUANTA   = 16'hFFFF,
   parameter int                       C_TIMER_WIDTH    = 20,
   parameter logic [C_TIMER_WIDTH-1:0] C_REFRESH_CYCLES = 20'd262000,
   parameter logic [7:0]               C_MIN_GAP_CYCLES = 8'd16,
   parameter int                       C_CNT_WIDTH      = 32
) (
   input  logic                    clk156,
   input  logic                    areset_clk156,
   input  logic                    enable,
   input  logic                    link_up,
   input  logic [C_FILL_WIDTH-1:0] fill_level,
   input  logic [C_FILL_WIDTH-1:0] high_water,
   input  logic [C_FILL_WIDTH-1:0] low_water,
   input  logic                    clear_counters,
   output logic [15:0]             s_axis_pause_tdata,
   output logic                    s_axis_pause_tvalid,
   output logic                    pause_active,
   output logic [C_CNT_WIDTH-1:0]  xoff_count,
   output logic [C_CNT_WIDTH-1:0]  xon_count
);

   // The refresh timer counts down from here to zero, so terminal count
   // lands C_REFRESH_CYCLES cycles after the XOFF pulse.
   localparam logic [C_TIMER_WIDTH-1:0] TIMER_LOAD = C_REFRESH_CYCLES - C_TIMER_WIDTH'(1);

   pause_state_e              state_q, state_d;
   logic [C_FILL_WIDTH-1:0]   fill_q, fill_d;
   logic [C_TIMER_WIDTH-1:0]  timer_q, timer_d;
   logic [7:0]                gap_q, gap_d;
   logic                      refresh_q, refresh_d;
   logic                      tvalid_q, tvalid_d;
   logic [15:0]               tdata_q, tdata_d;
   logic                      pause_active_q, pause_active_d;

   logic [C_FILL_WIDTH-1:0]   low_eff;
   logic                      hi;
   logic                      lo;
   logic                      gap_zero;
   logic                      xoff_pulse;
   logic                      xon_pulse;

   // fill sample and hysteresis thresholds; low mark clamped so it never exceeds high
   always_comb begin
      fill_d   = fill_level;
      low_eff  = (low_water < high_water) ? low_water : high_water;
      hi       = (fill_q >= high_water);
      lo       = (fill_q < low_eff);
      gap_zero = (gap_q == 8'd0);
   end

   // next-state, timer and refresh flag
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      refresh_d  = refresh_q;
      xoff_pulse = 1'b0;
      xon_pulse  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable && link_up && hi) begin
               state_d = ST_XOFF_REQ;
            end
         end
         ST_XOFF_REQ: begin
            if (!link_up) begin
               state_d   = ST_IDLE;
               refresh_d = 1'b0;
            end else if (!enable) begin
               // only a refresh has a pause in force that needs undoing
               state_d   = refresh_q ? ST_XON_REQ : ST_IDLE;
               refresh_d = 1'b0;
            end else if (lo && !refresh_q) begin
               state_d = ST_IDLE;
            end else if (gap_zero) begin
               xoff_pulse = 1'b1;
               timer_d    = TIMER_LOAD;
               refresh_d  = 1'b0;
               state_d    = ST_PAUSED;
            end
         end
         ST_PAUSED: begin
            if (!link_up) begin
               state_d = ST_IDLE;
            end else if (lo || !enable) begin
               state_d = ST_XON_REQ;
            end else if (timer_q == '0) begin
               state_d   = ST_XOFF_REQ;
               refresh_d = 1'b1;
            end else begin
               timer_d = timer_q - C_TIMER_WIDTH'(1);
            end
         end
         ST_XON_REQ: begin
            if (!link_up) begin
               state_d = ST_IDLE;
            end else if (enable && hi) begin
               // pause still in force; timer resumes where it stopped
               state_d = ST_PAUSED;
            end else if (gap_zero) begin
               xon_pulse = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            refresh_d = 1'b0;
         end
      endcase
   end

   // pulse outputs, gap counter and pause indication
   always_comb begin
      tvalid_d = xoff_pulse | xon_pulse;
      tdata_d  = tdata_q;
      if (xoff_pulse) begin
         tdata_d = C_PAUSE_QUANTA;
      end else if (xon_pulse) begin
         tdata_d = XON_QUANTA;
      end
      if (xoff_pulse || xon_pulse) begin
         gap_d = C_MIN_GAP_CYCLES;
      end else if (!gap_zero) begin
         gap_d = gap_q - 8'd1;
      end else begin
         gap_d = 8'd0;
      end
      pause_active_d = (state_d == ST_PAUSED) || (state_d == ST_XON_REQ) ||
                       ((state_d == ST_XOFF_REQ) && refresh_d);
   end

   // state and datapath registers
   always_ff @(posedge clk156) begin
      if (areset_clk156) begin
         state_q        <= ST_IDLE;
         fill_q         <= '0;
         timer_q        <= '0;
         gap_q          <= 8'd0;
         refresh_q      <= 1'b0;
         tvalid_q       <= 1'b0;
         tdata_q        <= 16'h0000;
         pause_active_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         fill_q         <= fill_d;
         timer_q        <= timer_d;
         gap_q          <= gap_d;
         refresh_q      <= refresh_d;
         tvalid_q       <= tvalid_d;
         tdata_q        <= tdata_d;
         pause_active_q <= pause_active_d;
      end
   end

   nf_sat_counter #(.WIDTH(C_CNT_WIDTH)) u_xoff_cnt (
      .clk   (clk156),
      .rst   (areset_clk156),
      .inc   (xoff_pulse),
      .clr   (clear_counters),
      .count (xoff_count)
   );

   nf_sat_counter #(.WIDTH(C_CNT_WIDTH)) u_xon_cnt (
      .clk   (clk156),
      .rst   (areset_clk156),
      .inc   (xon_pulse),
      .clr   (clear_counters),
      .count (xon_count)
   );

   assign s_axis_pause_tdata  = tdata_q;
   assign s_axis_pause_tvalid = tvalid_q;
   assign pause_active        = pause_active_q;

endmodule

// File: tb/tb_nf_10g_pause_scheduler.sv
// Directed bench for nf_10g_pause_scheduler (refresh 100, gap 4, 4-bit counters).
module tb_nf_10g_pause_scheduler;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          link_up;
   logic [11:0]   fill_level;
   logic [11:0]   high_water;
   logic [11:0]   low_water;
   logic          clear_counters;
   logic [15:0]   tdata;
   logic          tvalid;
   logic          pause_active;
   logic [CW-1:0] xoff_count;
   logic [CW-1:0] xon_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   nf_10g_pause_scheduler #(
      .C_FILL_WIDTH     (12),
      .C_PAUSE_QUANTA   (16'hFFFF),
      .C_TIMER_WIDTH    (20),
      .C_REFRESH_CYCLES (20'd100),
      .C_MIN_GAP_CYCLES (8'd4),
      .C_CNT_WIDTH      (CW)
   ) dut (
      .clk156              (clk),
      .areset_clk156       (rst),
      .enable              (enable),
      .link_up             (link_up),
      .fill_level          (fill_level),
      .high_water          (high_water),
      .low_water           (low_water),
      .clear_counters      (clear_counters),
      .s_axis_pause_tdata  (tdata),
      .s_axis_pause_tvalid (tvalid),
      .pause_active        (pause_active),
      .xoff_count          (xoff_count),
      .xon_count           (xon_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pulse(input int max_cyc, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < max_cyc && !ok) begin
         tick();
         n++;
         if (tvalid) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; link_up = 1'b1; clear_counters = 1'b0;
      fill_level = 12'd0; high_water = 12'd800; low_water = 12'd200;
      repeat (3) tick();
      checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", tvalid); end
      checks++; if (tdata !== 16'h0000) begin failures++; $display("FAIL rst_tdata got=%h exp=0000", tdata); end
      checks++; if (pause_active !== 1'b0) begin failures++; $display("FAIL rst_pause got=%b exp=0", pause_active); end
      checks++; if (xoff_count !== 4'd0) begin failures++; $display("FAIL rst_xoff got=%0d exp=0", xoff_count); end
      checks++; if (xon_count !== 4'd0) begin failures++; $display("FAIL rst_xon got=%0d exp=0", xon_count); end
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_xoff_latency();
      fill_level = 12'd800;
      tick(); tick();
      checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL xoff_early got=%b exp=0", tvalid); end
      tick();
      checks++; if (tvalid !== 1'b1) begin failures++; $display("FAIL xoff_lat_tvalid got=%b exp=1", tvalid); end
      checks++; if (tdata !== 16'hFFFF) begin failures++; $display("FAIL xoff_lat_tdata got=%h exp=FFFF", tdata); end
      checks++; if (pause_active !== 1'b1) begin failures++; $display("FAIL xoff_lat_pause got=%b exp=1", pause_active); end
      checks++; if (xoff_count !== 4'd1) begin failures++; $display("FAIL xoff_lat_count got=%0d exp=1", xoff_count); end
   endtask

   task automatic test_refresh();
      int n; bit ok; int bad;
      fill_level = 12'd900;
      for (int r = 0; r < 3; r++) begin
         n = 0; ok = 1'b0; bad = 0;
         while (n < 150 && !ok) begin
            tick();
            n++;
            if (tvalid) ok = 1'b1;
            else if (!pause_active) bad++;
         end
         checks++; if (!ok || n != 101) begin failures++; $display("FAIL refresh_period r=%0d got=%0d exp=101", r, n); end
         checks++; if (tdata !== 16'hFFFF) begin failures++; $display("FAIL refresh_tdata got=%h exp=FFFF", tdata); end
         checks++; if (bad != 0) begin failures++; $display("FAIL refresh_pause_drop got=%0d exp=0", bad); end
      end
      checks++; if (xoff_count !== 4'd4) begin failures++; $display("FAIL refresh_count got=%0d exp=4", xoff_count); end
   endtask

   task automatic test_xon();
      int p;
      fill_level = 12'd200;
      p = 0;
      repeat (8) begin tick(); if (tvalid) p++; end
      checks++; if (p != 0) begin failures++; $display("FAIL xon_at_low got=%0d pulses exp=0", p); end
      checks++; if (pause_active !== 1'b1) begin failures++; $display("FAIL xon_at_low_pause got=%b exp=1", pause_active); end
      fill_level = 12'd199;
      tick(); tick();
      checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL xon_early got=%b exp=0", tvalid); end
      tick();
      checks++; if (tvalid !== 1'b1 || tdata !== 16'h0000) begin failures++; $display("FAIL xon_pulse got=%b/%h exp=1/0000", tvalid, tdata); end
      checks++; if (pause_active !== 1'b0) begin failures++; $display("FAIL xon_pause got=%b exp=0", pause_active); end
      checks++; if (xon_count !== 4'd1) begin failures++; $display("FAIL xon_count got=%0d exp=1", xon_count); end
   endtask

   task automatic test_gap_cancel();
      int p;
      fill_level = 12'd800;
      tick();
      fill_level = 12'd100;
      p = 0;
      repeat (12) begin tick(); if (tvalid) p++; end
      checks++; if (p != 0) begin failures++; $display("FAIL gap_cancel got=%0d pulses exp=0", p); end
      checks++; if (xoff_count !== 4'd4) begin failures++; $display("FAIL gap_cancel_count got=%0d exp=4", xoff_count); end
      checks++; if (pause_active !== 1'b0) begin failures++; $display("FAIL gap_cancel_pause got=%b exp=0", pause_active); end
   endtask

   task automatic test_link_enable();
      int n; bit ok; int p; logic [15:0] seen;
      fill_level = 12'd800;
      wait_pulse(20, n, ok);
      checks++; if (!ok || xoff_count !== 4'd5) begin failures++; $display("FAIL link_pre_xoff got=%b/%0d exp=1/5", ok, xoff_count); end
      link_up = 1'b0;
      tick();
      checks++; if (pause_active !== 1'b0) begin failures++; $display("FAIL link_down_pause got=%b exp=0", pause_active); end
      p = 0;
      repeat (10) begin tick(); if (tvalid) p++; end
      checks++; if (p != 0) begin failures++; $display("FAIL link_down_pulse got=%0d exp=0", p); end
      link_up = 1'b1;
      wait_pulse(20, n, ok);
      checks++; if (!ok || tdata !== 16'hFFFF || xoff_count !== 4'd6) begin failures++; $display("FAIL link_up_xoff got=%b/%h/%0d exp=1/FFFF/6", ok, tdata, xoff_count); end
      enable = 1'b0;
      p = 0; seen = 16'h1234;
      repeat (20) begin tick(); if (tvalid) begin p++; seen = tdata; end end
      checks++; if (p != 1 || seen !== 16'h0000) begin failures++; $display("FAIL disable_xon got=%0d/%h exp=1/0000", p, seen); end
      checks++; if (pause_active !== 1'b0 || xon_count !== 4'd2) begin failures++; $display("FAIL disable_state got=%b/%0d exp=0/2", pause_active, xon_count); end
      fill_level = 12'd0;
      enable = 1'b1;
      repeat (10) tick();
   endtask

   task automatic test_inverted_saturate();
      int cyc; int last; bit last_xoff; int n_xoff; int n_xon; int sp_err; int alt_err;
      clear_counters = 1'b1;
      tick();
      clear_counters = 1'b0;
      checks++; if (xoff_count !== 4'd0 || xon_count !== 4'd0) begin failures++; $display("FAIL clear got=%0d/%0d exp=0/0", xoff_count, xon_count); end
      low_water = 12'd900;
      cyc = 0; last = -100; last_xoff = 1'b0; n_xoff = 0; n_xon = 0; sp_err = 0; alt_err = 0;
      for (int k = 0; k < 42; k++) begin
         fill_level = (k % 2 == 0) ? 12'd801 : 12'd799;
         if (k >= 40) fill_level = 12'd0;
         repeat (8) begin
            tick();
            cyc++;
            if (tvalid) begin
               if (cyc - last < 5) sp_err++;
               last = cyc;
               if (tdata == 16'hFFFF) begin
                  if (last_xoff) alt_err++;
                  last_xoff = 1'b1; n_xoff++;
               end else begin
                  if (!last_xoff) alt_err++;
                  last_xoff = 1'b0; n_xon++;
               end
            end
         end
      end
      checks++; if (n_xoff < 16 || n_xon < 16) begin failures++; $display("FAIL inv_pulses got=%0d/%0d exp>=16/16", n_xoff, n_xon); end
      checks++; if (sp_err != 0) begin failures++; $display("FAIL inv_spacing got=%0d exp=0", sp_err); end
      checks++; if (alt_err != 0) begin failures++; $display("FAIL inv_alternate got=%0d exp=0", alt_err); end
      checks++; if (xoff_count !== 4'hF || xon_count !== 4'hF) begin failures++; $display("FAIL saturate got=%0d/%0d exp=15/15", xoff_count, xon_count); end
   endtask

   task automatic test_clear_coincident();
      int n; bit ok;
      fill_level = 12'd801;
      tick(); tick();
      clear_counters = 1'b1;
      tick();
      clear_counters = 1'b0;
      checks++; if (tvalid !== 1'b1 || xoff_count !== 4'd0) begin failures++; $display("FAIL clr_coinc got=%b/%0d exp=1/0", tvalid, xoff_count); end
      tick();
      checks++; if (xoff_count !== 4'd0) begin failures++; $display("FAIL clr_after got=%0d exp=0", xoff_count); end
      fill_level = 12'd799;
      wait_pulse(20, n, ok);
      checks++; if (!ok || tdata !== 16'h0000 || xon_count !== 4'd1) begin failures++; $display("FAIL clr_then_xon got=%b/%h/%0d exp=1/0000/1", ok, tdata, xon_count); end
   endtask

   task automatic test_reset_mid();
      int n; bit ok; int p;
      fill_level = 12'd801;
      wait_pulse(20, n, ok);
      checks++; if (!ok || pause_active !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b/%b exp=1/1", ok, pause_active); end
      rst = 1'b1;
      p = 0;
      repeat (3) begin tick(); if (tvalid) p++; end
      checks++; if (p != 0 || pause_active !== 1'b0 || tdata !== 16'h0000 || xoff_count !== 4'd0) begin
         failures++; $display("FAIL mid_reset got=%0d/%b/%h/%0d exp=0/0/0000/0", p, pause_active, tdata, xoff_count);
      end
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_xoff_latency();
      test_refresh();
      test_xon();
      test_gap_cancel();
      test_link_enable();
      test_inverted_saturate();
      test_clear_coincident();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
